// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the ALU execute stage.
package alu_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_SRA = 4'd7,
        OP_SLT = 4'd8,
        OP_MUL = 4'd9
    } op_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_e;

    // Opcodes 10-15 are NOPs: they still produce a result pulse but never write.
    function automatic logic is_nop(input logic [OPCODE_W-1:0] op);
        return (op > 4'd9);
    endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per clock after start.
module mul_iter #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_next_s;
    logic [CW-1:0]    count_r;
    logic             busy_r;

    // The final step's sum is exposed directly so the product is ready on the done edge.
    assign acc_next_s = acc_r + (mplier_r[0] ? mcand_r : {WIDTH{1'b0}});
    assign product    = acc_next_s;
    assign busy       = busy_r;
    assign done       = busy_r && (count_r == CW'(MUL_CYCLES - 1));

    // Operand load on start, then shift-add iterations until the last count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            count_r  <= '0;
            busy_r   <= 1'b0;
        end else if (start) begin
            mcand_r  <= a;
            mplier_r <= b;
            acc_r    <= '0;
            count_r  <= '0;
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            if (done) begin
                count_r <= '0;
                busy_r  <= 1'b0;
            end else begin
                count_r <= count_r + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_stage.sv
// Single-issue ALU execute stage: one-cycle ALU ops plus a blocking iterative multiply.
module alu_stage
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] r1_value,
    input  logic [WIDTH-1:0] r2_value,
    input  logic [4:0]       rd_add,
    output logic [WIDTH-1:0] z4_output,
    output logic [4:0]       z4_write_add,
    output logic             z4_write_enable,
    output logic             z4_valid
);

    state_e           state_r;
    logic [4:0]       mul_rd_r;
    logic [WIDTH-1:0] alu_result_s;
    logic [4:0]       shamt_s;
    logic             accept_s;
    logic             mul_start_s;
    logic             mul_busy_s;
    logic             mul_done_s;
    logic [WIDTH-1:0] mul_product_s;

    assign in_ready    = (state_r == ST_IDLE) && !mul_busy_s;
    assign accept_s    = in_valid && in_ready;
    assign mul_start_s = accept_s && (opcode == OP_MUL);
    assign shamt_s     = r2_value[4:0];

    // Single-cycle result for every opcode except MUL; NOPs yield zero.
    always_comb begin
        alu_result_s = '0;
        case (opcode)
            OP_ADD:  alu_result_s = r1_value + r2_value;
            OP_SUB:  alu_result_s = r1_value - r2_value;
            OP_AND:  alu_result_s = r1_value & r2_value;
            OP_OR:   alu_result_s = r1_value | r2_value;
            OP_XOR:  alu_result_s = r1_value ^ r2_value;
            OP_SLL:  alu_result_s = r1_value << shamt_s;
            OP_SRL:  alu_result_s = r1_value >> shamt_s;
            OP_SRA:  alu_result_s = $unsigned($signed(r1_value) >>> shamt_s);
            OP_SLT:  alu_result_s = ($signed(r1_value) < $signed(r2_value)) ? WIDTH'(1) : '0;
            default: alu_result_s = '0;
        endcase
    end

    mul_iter #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start_s),
        .a       (r1_value),
        .b       (r2_value),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // Stage FSM and result register; valid and write strobe default low each cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            mul_rd_r        <= '0;
            z4_output       <= '0;
            z4_write_add    <= '0;
            z4_write_enable <= 1'b0;
            z4_valid        <= 1'b0;
        end else begin
            z4_valid        <= 1'b0;
            z4_write_enable <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (mul_start_s) begin
                        state_r  <= ST_MUL_BUSY;
                        mul_rd_r <= rd_add;
                    end else if (accept_s) begin
                        z4_output       <= alu_result_s;
                        z4_write_add    <= rd_add;
                        z4_valid        <= 1'b1;
                        z4_write_enable <= !is_nop(opcode);
                    end
                end
                ST_MUL_BUSY: begin
                    if (mul_done_s) begin
                        state_r         <= ST_IDLE;
                        z4_output       <= mul_product_s;
                        z4_write_add    <= mul_rd_r;
                        z4_valid        <= 1'b1;
                        z4_write_enable <= 1'b1;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_stage.sv
// Self-checking bench for alu_stage: directed corner cases plus randomized ALU/MUL traffic.
module tb_alu_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  opcode = 4'd0;
    logic [31:0] r1_value = 32'd0;
    logic [31:0] r2_value = 32'd0;
    logic [4:0]  rd_add = 5'd0;
    logic [31:0] z4_output;
    logic [4:0]  z4_write_add;
    logic        z4_write_enable;
    logic        z4_valid;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_out;
    logic [4:0]  last_add;
    logic        last_known;

    always #5 clk = ~clk;

    alu_stage dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .opcode          (opcode),
        .r1_value        (r1_value),
        .r2_value        (r2_value),
        .rd_add          (rd_add),
        .z4_output       (z4_output),
        .z4_write_add    (z4_write_add),
        .z4_write_enable (z4_write_enable),
        .z4_valid        (z4_valid)
    );

    // Reference semantics written from the instruction definitions.
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        logic [63:0] p;
        sh = int'(b % 32);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return a << sh;
            6: return a >> sh;
            7: return (a >> sh) | ((a >= 32'h8000_0000) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            9: begin p = 64'(a) * 64'(b); return p[31:0]; end
            default: return 32'h0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input int op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        in_valid = v;
        opcode   = 4'(op);
        r1_value = a;
        r2_value = b;
        rd_add   = rd;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 0, 32'd0, 32'd0, 5'd0);
        repeat (2) @(negedge clk);
        checks++;
        if ({z4_valid, z4_write_enable, z4_write_add, z4_output} !== 39'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {z4_valid, z4_write_enable, z4_write_add, z4_output});
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({in_ready, z4_valid, z4_write_enable} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release got rdy/vld/we=%b want 100", {in_ready, z4_valid, z4_write_enable});
        end
        last_out = 32'd0;
        last_add = 5'd0;
        last_known = 1'b1;
    endtask

    task automatic test_directed();
        logic [38:0] exp;
        drive(1'b1, 0, 32'hFFFF_FFFF, 32'd1, 5'd3);
        tick();
        exp = {1'b1, 1'b1, 5'd3, 32'd0};
        checks++;
        if ({z4_valid, z4_write_enable, z4_write_add, z4_output} !== exp) begin
            errors++;
            $display("FAIL add_wrap got %h want %h", {z4_valid, z4_write_enable, z4_write_add, z4_output}, exp);
        end
        drive(1'b1, 7, 32'h8000_0000, 32'd4, 5'd1);
        tick();
        checks++;
        if (z4_output !== 32'hF800_0000 || z4_valid !== 1'b1) begin
            errors++;
            $display("FAIL sra_signfill got %h want f8000000", z4_output);
        end
        drive(1'b1, 8, 32'hFFFF_FFFF, 32'd1, 5'd2);
        tick();
        checks++;
        if (z4_output !== 32'd1 || z4_valid !== 1'b1) begin
            errors++;
            $display("FAIL slt_signed got %h want 1", z4_output);
        end
        drive(1'b1, 6, 32'h8000_0000, 32'd31, 5'd4);
        tick();
        checks++;
        if (z4_output !== 32'd1 || z4_valid !== 1'b1) begin
            errors++;
            $display("FAIL srl_31 got %h want 1", z4_output);
        end
        drive(1'b1, 12, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9);
        tick();
        checks++;
        if ({in_ready, z4_valid, z4_write_enable} !== 3'b110) begin
            errors++;
            $display("FAIL nop_op12 got rdy/vld/we=%b want 110", {in_ready, z4_valid, z4_write_enable});
        end
        drive(1'b0, 0, 32'd0, 32'd0, 5'd0);
        tick();
        checks++;
        if ({z4_valid, z4_write_enable} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_nop got vld/we=%b want 00", {z4_valid, z4_write_enable});
        end
        last_known = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        int ops[3];
        ops = '{0, 1, 4};
        a = $urandom;
        b = $urandom;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ops[i], a, b, 5'(10 + i));
            tick();
            checks++;
            if ({z4_valid, z4_write_enable, z4_write_add, z4_output} !== {1'b1, 1'b1, 5'(10 + i), ref_alu(ops[i], a, b)}) begin
                errors++;
                $display("FAIL b2b_%0d got %h want %h", i, {z4_valid, z4_write_enable, z4_write_add, z4_output},
                         {1'b1, 1'b1, 5'(10 + i), ref_alu(ops[i], a, b)});
            end
        end
        last_out = ref_alu(4, a, b);
        last_add = 5'd12;
        last_known = 1'b1;
    endtask

    task automatic test_random_alu();
        for (int i = 0; i < 80; i++) begin
            int op;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0] rd;
            logic go;
            op = $urandom_range(0, 14);
            if (op >= 9) op = op + 1;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
            rd = 5'($urandom);
            go = ($urandom_range(0, 3) != 0);
            drive(go, op, a, b, rd);
            tick();
            checks++;
            if (go && op <= 8) begin
                if ({in_ready, z4_valid, z4_write_enable, z4_write_add, z4_output} !== {3'b111, rd, ref_alu(op, a, b)}) begin
                    errors++;
                    $display("FAIL rand_op%0d a=%h b=%h got %h want %h", op, a, b,
                             {z4_valid, z4_write_enable, z4_write_add, z4_output}, {2'b11, rd, ref_alu(op, a, b)});
                end
                last_out = ref_alu(op, a, b);
                last_add = rd;
                last_known = 1'b1;
            end else if (go) begin
                if ({z4_valid, z4_write_enable} !== 2'b10) begin
                    errors++;
                    $display("FAIL rand_nop%0d got vld/we=%b want 10", op, {z4_valid, z4_write_enable});
                end
                last_known = 1'b0;
            end else begin
                if ({z4_valid, z4_write_enable} !== 2'b00 ||
                    (last_known && {z4_write_add, z4_output} !== {last_add, last_out})) begin
                    errors++;
                    $display("FAIL rand_idle got %h want vld/we=00 held %h", {z4_valid, z4_write_enable, z4_write_add, z4_output},
                             {last_add, last_out});
                end
            end
        end
    endtask

    task automatic test_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int busy_cycles;
        logic [31:0] ha;
        logic [31:0] hb;
        ha = $urandom | 32'd1;
        hb = $urandom;
        drive(1'b1, 9, a, b, rd);
        tick();
        // An ADD is held on the inputs while the multiply runs; it must wait.
        drive(1'b1, 0, ha, hb, 5'd7);
        busy_cycles = 0;
        for (int i = 0; i < 32; i++) begin
            if (in_ready === 1'b0 && z4_valid === 1'b0) busy_cycles++;
            tick();
        end
        checks++;
        if (busy_cycles != 32) begin
            errors++;
            $display("FAIL mul_busy_window got %0d quiet cycles want 32", busy_cycles);
        end
        checks++;
        if ({in_ready, z4_valid, z4_write_enable, z4_write_add, z4_output} !== {3'b111, rd, ref_alu(9, a, b)}) begin
            errors++;
            $display("FAIL mul_pulse got %h want %h", {in_ready, z4_valid, z4_write_enable, z4_write_add, z4_output},
                     {3'b111, rd, ref_alu(9, a, b)});
        end
        tick();
        checks++;
        if ({z4_valid, z4_write_enable, z4_write_add, z4_output} !== {2'b11, 5'd7, ha + hb}) begin
            errors++;
            $display("FAIL mul_then_add got %h want %h", {z4_valid, z4_write_enable, z4_write_add, z4_output}, {2'b11, 5'd7, ha + hb});
        end
        drive(1'b0, 0, 32'd0, 32'd0, 5'd0);
        tick();
        checks++;
        if ({z4_valid, z4_write_enable, z4_write_add, z4_output} !== {2'b00, 5'd7, ha + hb}) begin
            errors++;
            $display("FAIL mul_hold got %h want %h", {z4_valid, z4_write_enable, z4_write_add, z4_output}, {2'b00, 5'd7, ha + hb});
        end
        last_out = ha + hb;
        last_add = 5'd7;
        last_known = 1'b1;
    endtask

    task automatic test_reset_mid_mul();
        int pulses;
        drive(1'b1, 9, $urandom | 32'd1, $urandom | 32'd1, 5'd21);
        tick();
        drive(1'b0, 0, 32'd0, 32'd0, 5'd0);
        repeat (9) tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({z4_valid, z4_write_enable, z4_write_add, z4_output} !== 39'd0) begin
            errors++;
            $display("FAIL async_reset got %h want 0", {z4_valid, z4_write_enable, z4_write_add, z4_output});
        end
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (z4_valid !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0 || {in_ready, z4_write_enable, z4_write_add, z4_output} !== 39'h40_0000_0000) begin
            errors++;
            $display("FAIL abort_mul got pulses=%0d rdy=%b out=%h want 0 pulses rdy=1 out=0", pulses, in_ready, z4_output);
        end
        drive(1'b1, 1, 32'd5, 32'd9, 5'd0);
        tick();
        checks++;
        if ({z4_valid, z4_write_enable, z4_write_add, z4_output} !== {2'b11, 5'd0, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL post_reset_sub got %h want %h", {z4_valid, z4_write_enable, z4_write_add, z4_output},
                     {2'b11, 5'd0, 32'hFFFF_FFFC});
        end
        drive(1'b0, 0, 32'd0, 32'd0, 5'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random_alu();
        test_mul(32'd7, 32'd6, 5'd5);
        test_mul($urandom, $urandom, 5'($urandom));
        test_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
        test_reset_mid_mul();
        test_random_alu();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
